// File: rtl/imem_dmem_arbiter_if.sv
// Shared-SRAM bus between fetch, memory stage and the unified SRAM.
// slave: the arbiter; master: pipeline plus SRAM environment.
interface imem_dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 64
);
  logic              flush;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_rvalid;
  logic [63:0]       inst_rdata;
  logic              data_req;
  logic [7:0]        data_we;
  logic [ADDR_W-1:0] data_addr;
  logic [63:0]       data_wdata;
  logic              data_rvalid;
  logic [63:0]       data_rdata;
  logic              sram_en;
  logic [7:0]        sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [63:0]       sram_wdata;
  logic [63:0]       sram_rdata;
  logic              stall_req_if;
  logic              stall_req_mem;

  modport slave (
    input  flush, inst_req, inst_addr,
    input  data_req, data_we, data_addr, data_wdata,
    input  sram_rdata,
    output inst_rvalid, inst_rdata,
    output data_rvalid, data_rdata,
    output sram_en, sram_we, sram_addr, sram_wdata,
    output stall_req_if, stall_req_mem
  );

  modport master (
    output flush, inst_req, inst_addr,
    output data_req, data_we, data_addr, data_wdata,
    output sram_rdata,
    input  inst_rvalid, inst_rdata,
    input  data_rvalid, data_rdata,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    input  stall_req_if, stall_req_mem
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Fetch/data arbiter for one synchronous 64-bit SRAM port.
// Data has priority; a starvation counter lets fetch through.
module imem_dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned ADDR_W     = 64
) (
  input logic                 clk,
  input logic                 rst,
  imem_dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  owner_e     owner_q, owner_d;
  logic [3:0] starve_q, starve_d;

  logic inst_ok;
  logic starve;
  logic grant_d;
  logic grant_i;

  assign inst_ok = bus.inst_req & ~bus.flush;
  assign starve  = (starve_q == SMAX) & inst_ok;
  assign grant_d = bus.data_req & ~starve;
  assign grant_i = inst_ok & ~grant_d;

  assign bus.stall_req_if  = inst_ok & ~grant_i;
  assign bus.stall_req_mem = bus.data_req & ~grant_d;

  // Steer the winner onto the SRAM port; idle port drives zeros.
  always_comb begin
    bus.sram_en    = grant_d | grant_i;
    bus.sram_we    = '0;
    bus.sram_addr  = '0;
    bus.sram_wdata = '0;
    unique case (1'b1)
      grant_d: begin
        bus.sram_we    = bus.data_we;
        bus.sram_addr  = bus.data_addr;
        bus.sram_wdata = bus.data_wdata;
      end
      grant_i: begin
        bus.sram_addr  = bus.inst_addr;
      end
      default: ;
    endcase
  end

  // Remember who owns the data returning next cycle.
  always_comb begin
    owner_d = OWN_NONE;
    unique case (1'b1)
      grant_d: owner_d = OWN_DATA;
      grant_i: owner_d = OWN_INST;
      default: owner_d = OWN_NONE;
    endcase
  end

  // Count consecutive denied fetch cycles, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!inst_ok || grant_i) begin
      starve_d = '0;
    end else if (starve_q != SMAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  // State registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign bus.inst_rvalid = (owner_q == OWN_INST) & ~bus.flush;
  assign bus.data_rvalid = (owner_q == OWN_DATA);
  assign bus.inst_rdata  = bus.inst_rvalid ? bus.sram_rdata : '0;
  assign bus.data_rdata  = bus.data_rvalid ? bus.sram_rdata : '0;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench for imem_dmem_arbiter.
// SRAM model plus transaction-level reference of grants/responses.
module tb_imem_dmem_arbiter;
  localparam int unsigned SM = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_dmem_arbiter_if #(.ADDR_W(64)) bus ();

  imem_dmem_arbiter #(.STARVE_MAX(SM), .ADDR_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errs = 0;
  int checks = 0;

  function automatic logic [63:0] init_word(logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0]};
  endfunction

  function automatic logic [63:0] merge(logic [63:0] o, logic [63:0] n,
                                        logic [7:0] we);
    logic [63:0] r;
    r = o;
    for (int b = 0; b < 8; b++)
      if (we[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  // SRAM environment: reads old word, then writes enabled bytes.
  logic [63:0] sram_mem [logic [63:0]];
  always @(posedge clk) begin
    if (bus.sram_en) begin
      logic [63:0] w;
      w = sram_mem.exists(bus.sram_addr) ? sram_mem[bus.sram_addr]
                                         : init_word(bus.sram_addr);
      bus.sram_rdata <= w;
      if (bus.sram_we != 8'h00)
        sram_mem[bus.sram_addr] = merge(w, bus.sram_wdata, bus.sram_we);
    end
  end

  // Reference model: memory contents, denied-fetch run, pending reply.
  logic [63:0] ref_mem [logic [63:0]];
  int          m_denied = 0;
  int          m_pend = 0;
  logic        m_pend_wr = 1'b0;
  logic [63:0] m_word = '0;

  logic        e_gi, e_gd, e_en, e_sif, e_smem, e_iv, e_dv;
  logic [7:0]  e_we;
  logic [63:0] e_addr, e_wdata, e_ird, e_drd;

  function automatic logic [63:0] ref_rd(logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic model_eval();
    logic ok, st;
    ok     = bus.inst_req && !bus.flush;
    st     = ok && (m_denied >= SM);
    e_gd   = bus.data_req && !st;
    e_gi   = ok && !e_gd;
    e_en   = e_gd || e_gi;
    e_we   = e_gd ? bus.data_we : 8'h00;
    e_addr = e_gd ? bus.data_addr : (e_gi ? bus.inst_addr : 64'h0);
    e_wdata = e_gd ? bus.data_wdata : 64'h0;
    e_sif  = ok && !e_gi;
    e_smem = bus.data_req && !e_gd;
    e_iv   = (m_pend == 1) && !bus.flush;
    e_dv   = (m_pend == 2);
    e_ird  = e_iv ? m_word : 64'h0;
    e_drd  = m_word;
  endtask

  task automatic model_commit();
    logic ok;
    ok = bus.inst_req && !bus.flush;
    m_pend_wr = 1'b0;
    if (e_gd) begin
      m_pend = 2;
      m_word = ref_rd(bus.data_addr);
      if (bus.data_we != 8'h00) begin
        m_pend_wr = 1'b1;
        ref_mem[bus.data_addr] = merge(m_word, bus.data_wdata, bus.data_we);
      end
    end else if (e_gi) begin
      m_pend = 1;
      m_word = ref_rd(bus.inst_addr);
    end else begin
      m_pend = 0;
    end
    if (e_gi || !ok) m_denied = 0;
    else if (m_denied < SM) m_denied++;
  endtask

  task automatic drive(input logic ir, input logic [63:0] ia,
                       input logic dr, input logic [7:0] we,
                       input logic [63:0] da, input logic [63:0] wd,
                       input logic fl);
    @(negedge clk);
    bus.inst_req   = ir;
    bus.inst_addr  = ia;
    bus.data_req   = dr;
    bus.data_we    = we;
    bus.data_addr  = da;
    bus.data_wdata = wd;
    bus.flush      = fl;
    #1;
    model_eval();
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_commit();
  endtask

  task automatic idle();
    drive(0, 64'h0, 0, 8'h00, 64'h0, 64'h0, 0);
  endtask

  task automatic test_reset();
    idle();
    checks++;
    if (bus.sram_en !== 1'b0 || bus.inst_rvalid !== 1'b0 ||
        bus.data_rvalid !== 1'b0 || bus.stall_req_if !== 1'b0 ||
        bus.stall_req_mem !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle en=%b iv=%b dv=%b sif=%b smem=%b want all 0",
               bus.sram_en, bus.inst_rvalid, bus.data_rvalid,
               bus.stall_req_if, bus.stall_req_mem);
    end
    @(negedge clk);
    rst = 1'b0;
    m_pend = 0;
    m_denied = 0;
    idle();
    step();
    idle();
    checks++;
    if (bus.inst_rvalid !== 1'b0 || bus.data_rvalid !== 1'b0 ||
        bus.sram_en !== 1'b0) begin
      errs++;
      $display("FAIL post_reset_idle iv=%b dv=%b en=%b want 0",
               bus.inst_rvalid, bus.data_rvalid, bus.sram_en);
    end
  endtask

  task automatic test_fetch();
    logic [63:0] a [3];
    a[0] = 64'h8000_0000;
    a[1] = 64'h8000_0004;
    a[2] = 64'h0;
    for (int i = 0; i < 3; i++) begin
      drive(i < 2, a[i], 0, 8'h00, 64'h0, 64'h0, 0);
      checks++;
      if (i < 2 && (bus.sram_en !== 1'b1 || bus.sram_addr !== a[i] ||
                    bus.sram_we !== 8'h00)) begin
        errs++;
        $display("FAIL fetch_drive%0d en=%b addr=%h we=%h want 1 %h 00",
                 i, bus.sram_en, bus.sram_addr, bus.sram_we, a[i]);
      end
      if (i > 0 && (bus.inst_rvalid !== 1'b1 ||
                    bus.inst_rdata !== init_word(a[i-1]))) begin
        errs++;
        $display("FAIL fetch_resp%0d iv=%b rd=%h want 1 %h", i,
                 bus.inst_rvalid, bus.inst_rdata, init_word(a[i-1]));
      end
      step();
    end
  endtask

  task automatic test_conflict();
    idle();
    step();
    for (int i = 0; i < 12; i++) begin
      logic want_i;
      want_i = (i % 4) == 3;
      drive(1, 64'h8000_0040, 1, 8'h00, 64'h8000_0080, 64'h0, 0);
      checks++;
      if (bus.stall_req_if !== !want_i || bus.stall_req_mem !== want_i ||
          bus.sram_addr !== (want_i ? 64'h8000_0040 : 64'h8000_0080)) begin
        errs++;
        $display("FAIL conflict%0d sif=%b smem=%b addr=%h want inst=%b",
                 i, bus.stall_req_if, bus.stall_req_mem, bus.sram_addr,
                 want_i);
      end
      step();
    end
  endtask

  task automatic test_write_read();
    drive(0, 64'h0, 1, 8'hFF, 64'h100, 64'hDEAD_BEEF_0123_4567, 0);
    checks++;
    if (bus.sram_we !== 8'hFF || bus.sram_addr !== 64'h100 ||
        bus.sram_wdata !== 64'hDEAD_BEEF_0123_4567) begin
      errs++;
      $display("FAIL write_drive we=%h addr=%h wd=%h", bus.sram_we,
               bus.sram_addr, bus.sram_wdata);
    end
    step();
    drive(0, 64'h0, 1, 8'h00, 64'h100, 64'h0, 0);
    checks++;
    if (bus.data_rvalid !== 1'b1) begin
      errs++;
      $display("FAIL write_ack dv=%b want 1", bus.data_rvalid);
    end
    step();
    idle();
    checks++;
    if (bus.data_rvalid !== 1'b1 ||
        bus.data_rdata !== 64'hDEAD_BEEF_0123_4567) begin
      errs++;
      $display("FAIL read_back dv=%b rd=%h want 1 deadbeef01234567",
               bus.data_rvalid, bus.data_rdata);
    end
    step();
  endtask

  task automatic test_flush();
    drive(1, 64'h8000_0010, 0, 8'h00, 64'h0, 64'h0, 0);
    step();
    drive(1, 64'h8000_0018, 1, 8'h00, 64'h8000_0020, 64'h0, 1);
    checks++;
    if (bus.inst_rvalid !== 1'b0 || bus.sram_addr !== 64'h8000_0020 ||
        bus.stall_req_if !== 1'b0 || bus.stall_req_mem !== 1'b0) begin
      errs++;
      $display("FAIL flush iv=%b addr=%h sif=%b smem=%b want 0 80000020 0 0",
               bus.inst_rvalid, bus.sram_addr, bus.stall_req_if,
               bus.stall_req_mem);
    end
    step();
    idle();
    checks++;
    if (bus.data_rvalid !== 1'b1 ||
        bus.data_rdata !== init_word(64'h8000_0020) ||
        bus.inst_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL flush_data dv=%b rd=%h iv=%b", bus.data_rvalid,
               bus.data_rdata, bus.inst_rvalid);
    end
    step();
  endtask

  task automatic test_random();
    logic ir, dr, fl;
    logic [7:0] we;
    logic [63:0] ia, da, wd;
    ir = 0; dr = 0; we = 0; ia = 0; da = 0; wd = 0;
    for (int i = 0; i < 400; i++) begin
      if (!(e_sif && !fl)) begin
        ir = $urandom_range(0, 3) != 0;
        ia = 64'h8000_0000 + 64'($urandom_range(0, 15) * 8);
      end
      if (!e_smem) begin
        dr = $urandom_range(0, 2) != 0;
        da = 64'h8000_0000 + 64'($urandom_range(0, 15) * 8);
        we = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
        wd = {32'($urandom), 32'($urandom)};
      end
      fl = $urandom_range(0, 7) == 0;
      drive(ir, ia, dr, we, da, wd, fl);
      checks++;
      if (bus.sram_en !== e_en || bus.sram_we !== e_we ||
          bus.sram_addr !== e_addr || bus.sram_wdata !== e_wdata ||
          bus.stall_req_if !== e_sif || bus.stall_req_mem !== e_smem) begin
        errs++;
        $display("FAIL rnd_drive%0d en=%b we=%h a=%h sif=%b smem=%b want %b %h %h %b %b",
                 i, bus.sram_en, bus.sram_we, bus.sram_addr,
                 bus.stall_req_if, bus.stall_req_mem,
                 e_en, e_we, e_addr, e_sif, e_smem);
      end
      checks++;
      if (bus.inst_rvalid !== e_iv || bus.inst_rdata !== e_ird ||
          bus.data_rvalid !== e_dv ||
          (e_dv && !m_pend_wr && bus.data_rdata !== e_drd)) begin
        errs++;
        $display("FAIL rnd_resp%0d iv=%b ird=%h dv=%b drd=%h want %b %h %b %h",
                 i, bus.inst_rvalid, bus.inst_rdata, bus.data_rvalid,
                 bus.data_rdata, e_iv, e_ird, e_dv, e_drd);
      end
      step();
    end
    fl = 0;
  endtask

  task automatic test_async_reset();
    idle();
    step();
    drive(1, 64'h8000_0008, 0, 8'h00, 64'h0, 64'h0, 0);
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.inst_rvalid !== 1'b0 || bus.inst_rdata !== 64'h0) begin
      errs++;
      $display("FAIL async_reset iv=%b rd=%h want 0 0", bus.inst_rvalid,
               bus.inst_rdata);
    end
    idle();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_pend = 0;
    m_denied = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++;
      if (bus.inst_rvalid !== 1'b0 || bus.data_rvalid !== 1'b0) begin
        errs++;
        $display("FAIL after_reset%0d iv=%b dv=%b want 0 0", i,
                 bus.inst_rvalid, bus.data_rvalid);
      end
      step();
    end
  endtask

  initial begin
    bus.flush = 0; bus.inst_req = 0; bus.inst_addr = 0;
    bus.data_req = 0; bus.data_we = 0; bus.data_addr = 0;
    bus.data_wdata = 0;
    test_reset();
    test_fetch();
    test_conflict();
    test_write_read();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_dmem_arbiter.md
Name: imem_dmem_arbiter

Overview:
- Shares one synchronous 64-bit SRAM port between two requesters: the instruction-fetch stage (inst) and the memory stage (data).
- Sits between the pipeline and the unified SRAM.
- Returns read data one cycle after grant.
- Raises per-stage stall requests that feed the pipeline stall vector.
- Data has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- STARVE_MAX, 3: consecutive denied inst cycles after which inst wins over data (1..15).
- ADDR_W, 64: address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  branch/flush; cancels the current and in-flight inst access.
- inst_req  in  1  fetch request (read-only).
- inst_addr  in  ADDR_W  fetch address.
- inst_rvalid  out  1  fetch data valid.
- inst_rdata  out  64  fetch data.
- data_req  in  1  memory-stage request.
- data_we  in  8  byte write enables; 0 means read.
- data_addr  in  ADDR_W  data address.
- data_wdata  in  64  write data.
- data_rvalid  out  1  completion pulse for both read and write.
- data_rdata  out  64  read data.
- sram_en  out  1  shared SRAM enable.
- sram_we  out  8  shared SRAM byte write enables.
- sram_addr  out  ADDR_W  shared SRAM address.
- sram_wdata  out  64  shared SRAM write data.
- sram_rdata  in  64  shared SRAM read data; valid the cycle after sram_en.
- stall_req_if  out  1  fetch must hold.
- stall_req_mem  out  1  memory stage must hold.

Behaviour:
- Grant is combinational each cycle:
  - inst_ok = inst_req & ~flush.
  - starve = (starve_cnt == STARVE_MAX) & inst_ok.
  - grant_d = data_req & ~starve.
  - grant_i = inst_ok & ~grant_d.
- SRAM drive:
  - sram_en = grant_d | grant_i.
  - When grant_d: addr/we/wdata come from the data port.
  - When grant_i: addr = inst_addr, we = 0, wdata = 0.
  - With no grant: all SRAM outputs are 0.
- Stalls (combinational):
  - stall_req_if = inst_ok & ~grant_i.
  - stall_req_mem = data_req & ~grant_d.
  - A requester holds its request and fields stable while its stall is high.
- Response tracking: a 2-bit register resp_owner in {NONE, INST, DATA}. This is the FSM.
  - Next value is DATA if grant_d, INST if grant_i, otherwise NONE.
  - NONE->INST/DATA, INST->any, DATA->any, every cycle with no wait states.
- Response outputs:
  - inst_rvalid = (resp_owner == INST) & ~flush.
  - data_rvalid = (resp_owner == DATA).
  - inst_rdata and data_rdata = sram_rdata when the matching valid is high, else 0.
  - For writes, data_rvalid is an acknowledge; data_rdata is don't-care but is still driven from sram_rdata.
- Latency: exactly 1 cycle from grant to valid; throughput of one access per cycle.
- starve_cnt (4-bit, saturating at STARVE_MAX):
  - Increments when inst_ok & ~grant_i.
  - Clears when grant_i, when ~inst_ok, or on flush.
- Boundary conditions:
  - Simultaneous requests: data wins unless starve; when starve, inst wins and data stalls for that cycle.
  - Flush in the same cycle as an inst request: no inst grant; SRAM may serve data.
  - Flush in the cycle after an inst grant: that inst_rvalid is suppressed.
  - Flush never affects data.
  - STARVE_MAX saturation: the counter never wraps.
- Reset (asynchronous): resp_owner = NONE, starve_cnt = 0. All registered-derived outputs (inst_rvalid, data_rvalid, rdata) are 0 immediately.
  - Combinational outputs follow the inputs; with no requests they are 0.
  - Reset mid-access drops the in-flight response; no valid is produced after reset release.

Test Plan:
- Reset, then idle: inst_req = data_req = 0 -> sram_en = 0, all valids 0, stalls 0, starve_cnt = 0.
- Fetch only: inst_req = 1, addr 0x8000_0000 -> sram_en = 1, sram_addr = 0x8000_0000, sram_we = 0. The next cycle inst_rvalid = 1 and inst_rdata = SRAM model word. Back-to-back 0x...0 and 0x...4 give one valid per cycle.
- Conflict: both request every cycle with STARVE_MAX = 3 -> data granted for 3 cycles with stall_req_if = 1. The 4th cycle grants inst (stall_req_mem = 1), the counter clears, and the pattern repeats D,D,D,I.
- Data write: data_we = 0xFF, addr 0x100, wdata 0xDEAD_BEEF_0123_4567 -> SRAM written, data_rvalid pulses the next cycle. A subsequent read of 0x100 returns the same value.
- Flush: inst granted at cycle N, flush = 1 at N+1 -> inst_rvalid = 0 at N+1 and no inst grant at N+1. A concurrent data request at N+1 is granted.
- Async reset asserted mid-fetch, between grant and response -> inst_rvalid drops to 0 without waiting for a clock edge. After release with no requests, no valid appears.
